multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle sequencing FSM for the RV64 datapath. It replaces the single-cycle opcode decoder with a state machine that steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- It handshakes with the instruction and data memories, and drives the same control signal set (branch, reg write, mem read/write, alu_src, alu_op) plus PC/IR write enables.
- It traps on illegal opcodes and on memory timeouts.

Parameters:
- TIMEOUT, 16, maximum wait cycles for imem_ready/dmem_ready before trapping (2..255).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- opcode  in  7  instr[6:0] from the instruction register; valid from DECODE onward
- zero  in  1  ALU zero flag (beq compare result)
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data access complete this cycle
- imem_req  out  1  instruction fetch request
- ir_write  out  1  load the IR with the fetched word
- pc_write  out  1  update the PC
- pc_sel  out  1  0 = PC+4, 1 = branch target
- branch  out  1  branch instruction in EXEC
- reg_write  out  1  register file write
- mem_to_reg  out  1  1 = writeback data from memory
- mem_read  out  1  data memory read request
- mem_write  out  1  data memory write request
- alu_src  out  1  1 = immediate operand
- alu_op  out  2  00 add, 01 compare (beq), 10 funct-decoded
- retired  out  1  one-cycle pulse when an instruction completes
- illegal  out  1  sticky: illegal opcode trap
- timeout  out  1  sticky: memory timeout trap

Behaviour:
- Reset:
  - Sampled on the clk rising edge while rst_n=0.
  - State goes to FETCH, the wait counter clears, opcode_q clears, illegal/timeout clear.
  - All outputs are 0 while rst_n is low, including in the cycle rst_n is sampled low.
  - The first cycle after release is FETCH with imem_req=1.
  - Reset mid-instruction abandons it: no pc_write and no retired pulse.
- Opcode latch: opcode_q is captured in DECODE. All later decoding uses opcode_q, so IR changes after DECODE are ignored.
- Legal opcodes and their decode:
  - 0110011 R-type: alu_src=0, alu_op=10
  - 0010011 I-type: alu_src=1, alu_op=10
  - 0000011 ld: alu_src=1, alu_op=00
  - 0100011 sd: alu_src=1, alu_op=00
  - 1100011 beq: alu_src=0, alu_op=01
- FETCH:
  - imem_req=1.
  - On imem_ready=1: ir_write=1 for that cycle, then go to DECODE.
- DECODE: one cycle, no datapath controls. Legal opcode goes to EXEC; any other opcode goes to TRAP and sets illegal=1.
- EXEC:
  - alu_src/alu_op are driven from opcode_q.
  - R/I go to WB. ld/sd go to MEM.
  - beq: branch=1, pc_write=1, pc_sel=zero, retired=1, then go to FETCH.
- MEM:
  - alu_src/alu_op are held at their EXEC values.
  - ld: mem_read=1 until dmem_ready=1, then go to WB.
  - sd: mem_write=1 until dmem_ready=1. In the dmem_ready cycle: pc_write=1, pc_sel=0, retired=1, then go to FETCH.
- WB:
  - reg_write=1, pc_write=1, pc_sel=0, retired=1.
  - mem_to_reg=1 for ld, 0 otherwise.
  - Then go to FETCH.
- TRAP:
  - All control outputs 0; illegal/timeout hold their values.
  - The only exit is reset.
- Any output not named for a state is 0 in that state.
- Timeout:
  - The wait counter clears on entry to FETCH and MEM and increments each cycle the ready input is low.
  - If the counter equals TIMEOUT-1 and ready is still low, the FSM goes to TRAP and sets timeout=1. This allows exactly TIMEOUT waiting cycles.
  - If ready rises in the same cycle the limit is reached, ready wins: normal transition, no trap.
- Latency with ready asserted in the first cycle: beq 3 cycles, R/I 4, sd 4, ld 5, measured from the first FETCH cycle to the retired cycle inclusive. Each wait cycle adds 1.
- pc_write and retired are asserted together, exactly once per instruction.

Test Plan:
- Reset, then R-type 0110011, imem_ready=1 always -> imem_req cycle 0; ir_write cycle 0; alu_op=10 cycle 2; reg_write=1, pc_write=1, pc_sel=0, retired=1 cycle 3; FETCH cycle 4.
- ld with dmem_ready low 3 cycles -> mem_read=1 for 4 cycles; WB has mem_to_reg=1, reg_write=1; retired in cycle 7.
- beq with zero=1, then with zero=0 -> pc_write=1 in EXEC with pc_sel=1 and 0 respectively; branch=1, alu_op=01; reg_write never asserted.
- sd, dmem_ready after 2 waits -> mem_write 3 cycles, pc_write/retired in the dmem_ready cycle, reg_write=0 throughout.
- Opcode 1111111 -> DECODE goes to TRAP, illegal=1, all controls 0 for 20 cycles; rst_n low for one cycle clears illegal and restarts FETCH.
- TIMEOUT=4, imem_ready held low -> TRAP after 4 FETCH cycles, timeout=1. Separate run with imem_ready rising in the 4th cycle -> no trap, DECODE next.
- rst_n low during MEM of sd -> no mem_write, pc_write or retired after the reset edge; FETCH after release.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle sequencing FSM for the RV64 datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, handshakes with the
// instruction and data memories, and traps on illegal opcodes or memory timeouts.
module multicycle_control #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_sel,
    output logic       branch,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       mem_read,
    output logic       mem_write,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic       retired,
    output logic       illegal,
    output logic       timeout
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_FN  = 2'b10;

    // Last counter value before a still-low ready forces the trap.
    localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT - 1);

    logic [2:0] state_q,   state_d;
    logic [7:0] cnt_q,     cnt_d;
    logic [6:0] opcode_q,  opcode_d;
    logic       illegal_q, illegal_d;
    logic       timeout_q, timeout_d;

    // Raw control values from the FSM, gated by rst_n at the ports.
    logic       c_imem_req, c_ir_write, c_pc_write, c_pc_sel, c_branch;
    logic       c_reg_write, c_mem_to_reg, c_mem_read, c_mem_write, c_alu_src;
    logic       c_retired;
    logic [1:0] c_alu_op;

    logic       op_legal;
    logic       op_is_ld;

    assign op_is_ld = (opcode_q == OP_LD);

    // Legality check on the live IR opcode, used only in DECODE.
    always_comb begin
        case (opcode)
            OP_R, OP_I, OP_LD, OP_SD, OP_BEQ: op_legal = 1'b1;
            default:                          op_legal = 1'b0;
        endcase
    end

    // Next-state, wait-counter and control-output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        opcode_d     = opcode_q;
        illegal_d    = illegal_q;
        timeout_d    = timeout_q;
        c_imem_req   = 1'b0;
        c_ir_write   = 1'b0;
        c_pc_write   = 1'b0;
        c_pc_sel     = 1'b0;
        c_branch     = 1'b0;
        c_reg_write  = 1'b0;
        c_mem_to_reg = 1'b0;
        c_mem_read   = 1'b0;
        c_mem_write  = 1'b0;
        c_alu_src    = 1'b0;
        c_alu_op     = ALU_ADD;
        c_retired    = 1'b0;

        // EXEC and MEM share the operand/ALU selection taken from the latched opcode.
        if (state_q == S_EXEC || state_q == S_MEM) begin
            case (opcode_q)
                OP_R:    begin c_alu_src = 1'b0; c_alu_op = ALU_FN;  end
                OP_I:    begin c_alu_src = 1'b1; c_alu_op = ALU_FN;  end
                OP_LD,
                OP_SD:   begin c_alu_src = 1'b1; c_alu_op = ALU_ADD; end
                OP_BEQ:  begin c_alu_src = 1'b0; c_alu_op = ALU_CMP; end
                default: begin c_alu_src = 1'b0; c_alu_op = ALU_ADD; end
            endcase
        end

        case (state_q)
            S_FETCH: begin
                c_imem_req = 1'b1;
                if (imem_ready) begin
                    c_ir_write = 1'b1;
                    state_d    = S_DECODE;
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d   = S_TRAP;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DECODE: begin
                opcode_d = opcode;
                if (op_legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_EXEC: begin
                case (opcode_q)
                    OP_BEQ: begin
                        c_branch   = 1'b1;
                        c_pc_write = 1'b1;
                        c_pc_sel   = zero;
                        c_retired  = 1'b1;
                        state_d    = S_FETCH;
                        cnt_d      = '0;
                    end
                    OP_LD, OP_SD: begin
                        state_d = S_MEM;
                        cnt_d   = '0;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                c_mem_read  = op_is_ld;
                c_mem_write = !op_is_ld;
                if (dmem_ready) begin
                    if (op_is_ld) begin
                        state_d = S_WB;
                    end else begin
                        c_pc_write = 1'b1;
                        c_retired  = 1'b1;
                        state_d    = S_FETCH;
                        cnt_d      = '0;
                    end
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d   = S_TRAP;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WB: begin
                c_reg_write  = 1'b1;
                c_pc_write   = 1'b1;
                c_retired    = 1'b1;
                c_mem_to_reg = op_is_ld;
                state_d      = S_FETCH;
                cnt_d        = '0;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            opcode_q  <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opcode_q  <= opcode_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Outputs forced low whenever rst_n is low, including the cycle it is sampled.
    assign imem_req   = rst_n & c_imem_req;
    assign ir_write   = rst_n & c_ir_write;
    assign pc_write   = rst_n & c_pc_write;
    assign pc_sel     = rst_n & c_pc_sel;
    assign branch     = rst_n & c_branch;
    assign reg_write  = rst_n & c_reg_write;
    assign mem_to_reg = rst_n & c_mem_to_reg;
    assign mem_read   = rst_n & c_mem_read;
    assign mem_write  = rst_n & c_mem_write;
    assign alu_src    = rst_n & c_alu_src;
    assign alu_op     = rst_n ? c_alu_op : '0;
    assign retired    = rst_n & c_retired;
    assign illegal    = rst_n & illegal_q;
    assign timeout    = rst_n & timeout_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each stimulus cycle pushes its
// hand-computed expected output vector; a monitor pops and compares on negedge.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic       zero = 1'b0;
    logic       imem_ready = 1'b0;
    logic       dmem_ready = 1'b0;
    logic       imem_req, ir_write, pc_write, pc_sel, branch, reg_write;
    logic       mem_to_reg, mem_read, mem_write, alu_src, retired, illegal, timeout;
    logic [1:0] alu_op;

    multicycle_control #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
        .pc_sel(pc_sel), .branch(branch), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .mem_read(mem_read), .mem_write(mem_write),
        .alu_src(alu_src), .alu_op(alu_op), .retired(retired),
        .illegal(illegal), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Output vector bit positions.
    localparam logic [14:0] IREQ = 15'h4000;
    localparam logic [14:0] IRW  = 15'h2000;
    localparam logic [14:0] PCW  = 15'h1000;
    localparam logic [14:0] PCS  = 15'h0800;
    localparam logic [14:0] BR   = 15'h0400;
    localparam logic [14:0] RW   = 15'h0200;
    localparam logic [14:0] M2R  = 15'h0100;
    localparam logic [14:0] MRD  = 15'h0080;
    localparam logic [14:0] MWR  = 15'h0040;
    localparam logic [14:0] ASRC = 15'h0020;
    localparam logic [14:0] AFN  = 15'h0010;
    localparam logic [14:0] ACMP = 15'h0008;
    localparam logic [14:0] RET  = 15'h0004;
    localparam logic [14:0] ILL  = 15'h0002;
    localparam logic [14:0] TOUT = 15'h0001;
    localparam logic [14:0] NONE = 15'h0000;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef struct {
        logic [14:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [14:0] dut_vec();
        return {imem_req, ir_write, pc_write, pc_sel, branch, reg_write, mem_to_reg,
                mem_read, mem_write, alu_src, alu_op, retired, illegal, timeout};
    endfunction

    // One clock cycle of stimulus plus its expected outputs.
    task automatic cyc(input logic r, input logic [6:0] op, input logic z,
                       input logic ir, input logic dr, input logic [14:0] e,
                       input string tag);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n      = r;
        opcode     = op;
        zero       = z;
        imem_ready = ir;
        dmem_ready = dr;
        x.v   = e;
        x.tag = tag;
        sb.push_back(x);
    endtask

    // Monitor: compares DUT outputs against the oldest queued expectation.
    initial begin
        exp_t x;
        logic [14:0] got;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x   = sb.pop_front();
                got = dut_vec();
                total++;
                if (got !== x.v) begin
                    bad++;
                    $display("FAIL %s got=%b exp=%b t=%0t", x.tag, got, x.v, $time);
                end
            end
        end
    end

    initial begin
        // Reset
        cyc(0, OP_R, 0, 1, 1, NONE, "rst0");
        cyc(0, OP_R, 0, 1, 1, NONE, "rst1");

        // R-type, ready immediately: retire in cycle 3
        cyc(1, OP_R,   0, 1, 0, IREQ | IRW,     "r_fetch");
        cyc(1, OP_R,   0, 0, 0, NONE,           "r_decode");
        cyc(1, OP_BAD, 0, 0, 0, AFN,            "r_exec");
        cyc(1, OP_BAD, 0, 0, 0, RW | PCW | RET, "r_wb");

        // I-type with two imem wait cycles
        cyc(1, OP_BAD, 0, 0, 0, IREQ,                  "i_fwait0");
        cyc(1, OP_BAD, 0, 0, 0, IREQ,                  "i_fwait1");
        cyc(1, OP_I,   0, 1, 0, IREQ | IRW,            "i_fetch");
        cyc(1, OP_I,   0, 0, 0, NONE,                  "i_decode");
        cyc(1, OP_BAD, 0, 0, 0, ASRC | AFN,            "i_exec");
        cyc(1, OP_BAD, 0, 0, 0, RW | PCW | RET,        "i_wb");

        // ld, dmem_ready low 3 cycles then high at the counter limit
        cyc(1, OP_LD,  0, 1, 0, IREQ | IRW,             "ld_fetch");
        cyc(1, OP_LD,  0, 0, 0, NONE,                   "ld_decode");
        cyc(1, OP_BAD, 0, 0, 0, ASRC,                   "ld_exec");
        cyc(1, OP_BAD, 0, 0, 0, MRD | ASRC,             "ld_mem0");
        cyc(1, OP_BAD, 0, 0, 0, MRD | ASRC,             "ld_mem1");
        cyc(1, OP_BAD, 0, 0, 0, MRD | ASRC,             "ld_mem2");
        cyc(1, OP_BAD, 0, 0, 1, MRD | ASRC,             "ld_mem3");
        cyc(1, OP_BAD, 0, 0, 0, RW | M2R | PCW | RET,   "ld_wb");

        // beq taken
        cyc(1, OP_BEQ, 1, 1, 0, IREQ | IRW,                   "beq1_fetch");
        cyc(1, OP_BEQ, 1, 0, 0, NONE,                         "beq1_decode");
        cyc(1, OP_BAD, 1, 0, 0, BR | PCW | PCS | RET | ACMP,  "beq1_exec");
        // beq not taken
        cyc(1, OP_BEQ, 0, 1, 0, IREQ | IRW,                   "beq0_fetch");
        cyc(1, OP_BEQ, 0, 0, 0, NONE,                         "beq0_decode");
        cyc(1, OP_BAD, 0, 0, 0, BR | PCW | RET | ACMP,        "beq0_exec");

        // sd, dmem_ready after 2 waits
        cyc(1, OP_SD,  0, 1, 0, IREQ | IRW,              "sd_fetch");
        cyc(1, OP_SD,  0, 0, 0, NONE,                    "sd_decode");
        cyc(1, OP_BAD, 0, 0, 0, ASRC,                    "sd_exec");
        cyc(1, OP_BAD, 0, 0, 0, MWR | ASRC,              "sd_mem0");
        cyc(1, OP_BAD, 0, 0, 0, MWR | ASRC,              "sd_mem1");
        cyc(1, OP_BAD, 0, 0, 1, MWR | ASRC | PCW | RET,  "sd_mem2");

        // imem_ready rises in the 4th FETCH cycle: ready wins, no trap
        cyc(1, OP_R,   0, 0, 0, IREQ,           "tlim_f0");
        cyc(1, OP_R,   0, 0, 0, IREQ,           "tlim_f1");
        cyc(1, OP_R,   0, 0, 0, IREQ,           "tlim_f2");
        cyc(1, OP_R,   0, 1, 0, IREQ | IRW,     "tlim_f3");
        cyc(1, OP_R,   0, 0, 0, NONE,           "tlim_decode");
        cyc(1, OP_R,   0, 0, 0, AFN,            "tlim_exec");
        cyc(1, OP_R,   0, 0, 0, RW | PCW | RET, "tlim_wb");

        // Reset during MEM of sd abandons it
        cyc(1, OP_SD, 0, 1, 0, IREQ | IRW, "rsd_fetch");
        cyc(1, OP_SD, 0, 0, 0, NONE,       "rsd_decode");
        cyc(1, OP_SD, 0, 0, 0, ASRC,       "rsd_exec");
        cyc(1, OP_SD, 0, 0, 0, MWR | ASRC, "rsd_mem0");
        cyc(0, OP_SD, 0, 0, 1, NONE,       "rsd_rst");
        cyc(1, OP_SD, 0, 0, 1, IREQ,       "rsd_refetch");
        cyc(1, OP_BEQ, 0, 1, 1, IREQ | IRW,            "rsd_beq_fetch");
        cyc(1, OP_BEQ, 0, 0, 1, NONE,                  "rsd_beq_decode");
        cyc(1, OP_BEQ, 0, 0, 1, BR | PCW | RET | ACMP, "rsd_beq_exec");

        // Illegal opcode: TRAP for 20 cycles, then reset clears it
        cyc(1, OP_BAD, 0, 1, 0, IREQ | IRW, "ill_fetch");
        cyc(1, OP_BAD, 0, 1, 1, NONE,       "ill_decode");
        for (int i = 0; i < 20; i++) cyc(1, OP_R, 1, 1, 1, ILL, "ill_trap");
        cyc(0, OP_R, 0, 1, 1, NONE,           "ill_rst");
        cyc(1, OP_R, 0, 1, 0, IREQ | IRW,     "ill_refetch");
        cyc(1, OP_R, 0, 0, 0, NONE,           "ill_r_decode");
        cyc(1, OP_R, 0, 0, 0, AFN,            "ill_r_exec");
        cyc(1, OP_R, 0, 0, 0, RW | PCW | RET, "ill_r_wb");

        // imem timeout: 4 FETCH cycles then TRAP with timeout
        for (int i = 0; i < 4; i++) cyc(1, OP_R, 0, 0, 0, IREQ, "ito_fetch");
        for (int i = 0; i < 3; i++) cyc(1, OP_R, 0, 1, 1, TOUT, "ito_trap");
        cyc(0, OP_R, 0, 0, 0, NONE, "ito_rst");

        // dmem timeout during sd MEM
        cyc(1, OP_SD, 0, 1, 0, IREQ | IRW, "dto_fetch");
        cyc(1, OP_SD, 0, 0, 0, NONE,       "dto_decode");
        cyc(1, OP_SD, 0, 0, 0, ASRC,       "dto_exec");
        for (int i = 0; i < 4; i++) cyc(1, OP_SD, 0, 0, 0, MWR | ASRC, "dto_mem");
        for (int i = 0; i < 3; i++) cyc(1, OP_SD, 0, 1, 1, TOUT, "dto_trap");
        cyc(0, OP_SD, 0, 0, 0, NONE, "dto_rst");
        cyc(1, OP_SD, 0, 0, 0, IREQ, "dto_refetch");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
